fabric_config_sequencer: RTL and testbench
==========================================

# fabric_config_sequencer

Byte-stream configuration loader for the tile array. It assembles incoming bytes into 32-bit address/data frames and drives each frame onto the shared `config_addr`/`config_data` bus for exactly one cycle. The tile address matchers decode that bus into per-module enables for clb (mod 4), cb1 (mod 5), cb0 (mod 6) and sb (mod 7). It sits between the off-chip bitstream interface and the array top level, and is the only driver of the configuration bus.

## Interface
- `GAP_CYCLES`, default 1: idle bus cycles inserted after every write. Legal range is 1..15.
- `clk` input, 1: single clock for the block and the fabric configuration registers.
- `reset` input, 1: asynchronous, active-high; clears all state and outputs.
- `start` input, 1: level sampled each cycle. Begins a load from IDLE or DONE.
- `abort` input, 1: synchronous; returns the block to IDLE from any state.
- `byte_in` input, 8: bitstream byte.
- `byte_valid` input, 1: `byte_in` is valid this cycle.
- `byte_ready` output, 1: the sequencer accepts a byte this cycle.
- `config_addr` output, 32: `[15:0]` is tile_id, `[31:16]` is mod id. Value 0 when idle.
- `config_data` output, 32: configuration payload.
- `busy` output, 1: high in LOAD, WRITE and GAP.
- `done` output, 1: high in DONE.
- `frame_count` output, 16: number of frames written since the last start. Saturates.

## Operation
- States and transitions:
  - IDLE goes to LOAD when `start` is high.
  - LOAD goes to WRITE once 8 bytes are collected and the assembled address is nonzero.
  - LOAD goes to DONE once 8 bytes are collected and the assembled address is zero.
  - WRITE goes to GAP after one cycle.
  - GAP goes to LOAD after `GAP_CYCLES` cycles.
  - DONE goes to LOAD when `start` is high.
  - `abort` sends any state to IDLE.
- Frame format, little-endian, 8 bytes:
  - bytes 0-3 are the address (byte 0 → `addr[7:0]`);
  - bytes 4-7 are the data (byte 4 → `data[7:0]`).
- Byte index counter runs 0..7. It clears on `start`, `abort`, reset, and on acceptance of byte 7.
- A byte is accepted when `byte_valid && byte_ready`. `byte_ready` is high only in LOAD.
- Terminator frame: assembled address equals 0 (mod id 0 matches no module).
  - No write is issued and `frame_count` is unchanged.
  - Next state is DONE.
- `config_addr` is 0 in every state except WRITE, so no address matcher fires outside a write.
- `config_data` holds its last written value outside WRITE; it resets to 0.
- `frame_count`:
  - clears to 0 on the `start` transition into LOAD;
  - increments by 1 on entering WRITE;
  - saturates at 0xFFFF (no wrap);
  - holds through DONE and IDLE.
- `abort` and `start` high in the same cycle: `abort` wins.
- `start` while in LOAD, WRITE or GAP: ignored.
- `abort` mid-frame: partially assembled bytes are discarded and `frame_count` holds.
- Reset values:
  - state IDLE, byte index 0, GAP counter 0;
  - `config_addr` = 0, `config_data` = 0, `frame_count` = 0;
  - `byte_ready` = 0, `busy` = 0, `done` = 0.

## Timing
- All outputs are registered, except `byte_ready`, `busy` and `done`, which decode directly from the state register.
- Byte 7 accepted at edge N:
  - `config_addr`/`config_data` show the frame during cycle N..N+1;
  - the fabric captures the write at edge N+1;
  - `config_addr` returns to 0 after edge N+1.
- Minimum frame period: 8 accept cycles + 1 WRITE + `GAP_CYCLES`. This is 10 cycles at the default.
- Terminator byte 7 accepted at edge N: `done` = 1 and `busy` = 0 from edge N onward.
- `start` sampled high at edge N in IDLE or DONE: `byte_ready` = 1 during the cycle after edge N.
- `abort` sampled at edge N: IDLE from edge N, and `config_addr` = 0 from edge N.
- `reset` assertion clears outputs immediately, without waiting for `clk`, including mid-WRITE.
- Release of `reset` is synchronized externally.

## Test plan
- Single frame: `start`, then bytes 05 00 04 00 | 03 00 00 00, then terminator 00×8.
  - `config_addr` = 0x0004_0005 and `config_data` = 0x0000_0003 for exactly 1 cycle.
  - `frame_count` = 1, then `done` = 1 and `busy` = 0.
- Back-to-back: 4 frames with `byte_valid` held high.
  - Exactly 4 single-cycle writes, 10 cycles apart.
  - `config_addr` = 0 on every other cycle, and `byte_ready` = 0 during WRITE/GAP.
- Stalled stream: randomly deassert `byte_valid` mid-frame (e.g. 3 idle cycles after byte 2).
  - The write is delayed by exactly the stall count and the frame content is unchanged.
- Abort: `abort` after byte 5 of frame 2, then `start` and one full frame.
  - No write for the aborted frame.
  - `frame_count` = 0 after the restart, then 1.
- Async reset: assert `reset` off-edge during WRITE.
  - `config_addr` and `config_data` are 0 before the next `clk` edge.
  - State is IDLE and `byte_ready` = 0.
- Saturation: force `frame_count` near its limit (or load 65,537 frames).
  - `frame_count` stays at 0xFFFF and writes continue.
- `start` and `abort` high in the same cycle: the block stays in IDLE.

Source files
------------

// File: rtl/fabric_config_sequencer.sv
// Byte-stream configuration loader: assembles 8-byte little-endian address/data frames
// and drives each one onto the fabric configuration bus for exactly one cycle.
module fabric_config_sequencer #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] config_addr,
    output logic [31:0] config_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  byte_idx_q;
    logic [3:0]  gap_cnt_q;
    logic [55:0] frame_q;
    logic [31:0] config_addr_q;
    logic [31:0] config_data_q;
    logic [15:0] frame_count_q;

    logic        accept;
    logic [31:0] asm_addr_d;
    logic [31:0] asm_data_d;

    // Byte 7 never lands in frame_q: it is merged straight into the data word.
    assign accept     = byte_valid && byte_ready;
    assign asm_addr_d = frame_q[31:0];
    assign asm_data_d = {byte_in, frame_q[55:32]};

    assign byte_ready  = (state_q == S_LOAD);
    assign busy        = (state_q == S_LOAD) || (state_q == S_WRITE) || (state_q == S_GAP);
    assign done        = (state_q == S_DONE);
    assign config_addr = config_addr_q;
    assign config_data = config_data_q;
    assign frame_count = frame_count_q;

    // NOTE: every register here uses <= so all updates see pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            byte_idx_q    <= '0;
            gap_cnt_q     <= '0;
            frame_q       <= '0;
            config_addr_q <= '0;
            config_data_q <= '0;
            frame_count_q <= '0;
        end else if (abort) begin
            state_q       <= S_IDLE;
            byte_idx_q    <= '0;
            gap_cnt_q     <= '0;
            config_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q       <= S_LOAD;
                        byte_idx_q    <= '0;
                        frame_count_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (byte_idx_q == 3'd7) begin
                            byte_idx_q <= '0;
                            if (asm_addr_d != '0) begin
                                state_q       <= S_WRITE;
                                config_addr_q <= asm_addr_d;
                                config_data_q <= asm_data_d;
                                if (frame_count_q != 16'hFFFF) begin
                                    frame_count_q <= frame_count_q + 16'd1;
                                end
                            end else begin
                                state_q <= S_DONE;
                            end
                        end else begin
                            frame_q[{byte_idx_q, 3'b000} +: 8] <= byte_in;
                            byte_idx_q <= byte_idx_q + 3'd1;
                        end
                    end
                end
                S_WRITE: begin
                    state_q       <= S_GAP;
                    config_addr_q <= '0;
                    gap_cnt_q     <= '0;
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q   <= S_LOAD;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fabric_config_sequencer.sv
// Randomized bench for fabric_config_sequencer: the driver feeds a frame-level model that
// queues expected writes; a monitor pops and compares every write seen on the bus.
module tb_fabric_config_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    fabric_config_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .config_addr(config_addr),
        .config_data(config_data),
        .busy       (busy),
        .done       (done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [15:0] count;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          wr_cycles[$];
    logic [7:0]  model_bytes[$];
    logic [15:0] model_count = 16'h0000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: any nonzero address on the bus is a write and must match the head of the queue.
    always @(negedge clk) begin
        if (config_addr != 32'h0) begin
            wr_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {32'h0, config_addr}, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("write_addr", {32'h0, config_addr}, {32'h0, mon_e.addr});
                check("write_data", {32'h0, config_data}, {32'h0, mon_e.data});
                check("write_count", {48'h0, frame_count}, {48'h0, mon_e.count});
                check("write_ready_low", {63'h0, byte_ready}, 64'h0);
            end
        end
    end

    // Frame-level reference: every 8 accepted bytes form a frame; nonzero address => one write.
    task automatic model_accept(input logic [7:0] b, input int acc);
        logic [31:0] a;
        logic [31:0] d;
        model_bytes.push_back(b);
        if (model_bytes.size() == 8) begin
            a = {model_bytes[3], model_bytes[2], model_bytes[1], model_bytes[0]};
            d = {model_bytes[7], model_bytes[6], model_bytes[5], model_bytes[4]};
            model_bytes.delete();
            if (a != 32'h0) begin
                if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
                exp_q.push_back('{addr: a, data: d, count: model_count, cyc: acc});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int stall);
        int waited;
        repeat (stall) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        waited     = 0;
        while (!byte_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            check("byte_ready_timeout", {63'h0, byte_ready}, 64'h1);
            byte_valid = 1'b0;
            return;
        end
        model_accept(b, cyc + 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] d,
                              input int stall_at, input int stall_len, input bit rnd);
        logic [63:0] f;
        int s;
        f = {d, a};
        for (int i = 0; i < 8; i++) begin
            s = 0;
            if (i == stall_at) s = stall_len;
            else if (rnd && $urandom_range(0, 3) == 0) s = int'($urandom_range(1, 3));
            send_byte(f[8*i +: 8], s);
        end
        if (a == 32'h0) begin
            check("term_done", {63'h0, done}, 64'h1);
            check("term_busy", {63'h0, busy}, 64'h0);
            check("term_ready", {63'h0, byte_ready}, 64'h0);
            check("term_count", {48'h0, frame_count}, {48'h0, model_count});
        end
    endtask

    task automatic rand_frame();
        logic [31:0] a;
        a = {16'(4 + $urandom_range(0, 3)), 16'($urandom)};
        send_frame(a, $urandom, -1, 0, 1'b1);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_count = 16'h0;
        model_bytes.delete();
        check("start_ready", {63'h0, byte_ready}, 64'h1);
        check("start_count_clear", {48'h0, frame_count}, 64'h0);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        model_bytes.delete();
        check("abort_ready", {63'h0, byte_ready}, 64'h0);
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_addr", {32'h0, config_addr}, 64'h0);
        check("abort_count_hold", {48'h0, frame_count}, {48'h0, model_count});
    endtask

    initial begin
        int base;
        logic [63:0] f;

        #2;
        check("rst_addr", {32'h0, config_addr}, 64'h0);
        check("rst_data", {32'h0, config_data}, 64'h0);
        check("rst_count", {48'h0, frame_count}, 64'h0);
        check("rst_flags", {61'h0, byte_ready, busy, done}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single frame then terminator
        do_start();
        send_frame(32'h0004_0005, 32'h0000_0003, -1, 0, 1'b0);
        send_frame(32'h0, 32'h0, -1, 0, 1'b0);

        // Back-to-back, byte_valid held high: writes exactly 10 cycles apart
        do_start();
        base = wr_cycles.size();
        for (int k = 0; k < 4; k++) send_frame({16'(4 + k), 16'(k * 17 + 1)}, $urandom, -1, 0, 1'b0);
        send_frame(32'h0, 32'h0, -1, 0, 1'b0);
        check("b2b_writes", 64'(wr_cycles.size() - base), 64'd4);
        if (wr_cycles.size() - base == 4) begin
            for (int k = 1; k < 4; k++)
                check("b2b_period", 64'(wr_cycles[base + k] - wr_cycles[base + k - 1]), 64'd10);
        end

        // Stalled stream: 3 idle cycles before byte 3, then random stalls
        do_start();
        send_frame(32'h0007_00A5, 32'h1234_5678, 3, 3, 1'b0);
        for (int k = 0; k < 6; k++) rand_frame();
        send_frame(32'h0, 32'h0, -1, 0, 1'b1);

        // Abort after byte 5 of frame 2, then restart with one frame
        do_start();
        rand_frame();
        f = {32'hDEAD_BEEF, 32'h0005_0042};
        for (int i = 0; i < 6; i++) send_byte(f[8*i +: 8], 0);
        do_abort();
        do_start();
        rand_frame();
        send_frame(32'h0, 32'h0, -1, 0, 1'b0);

        // start and abort together: abort wins, block stays in IDLE
        do_abort();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_ready", {63'h0, byte_ready}, 64'h0);
        check("start_abort_flags", {62'h0, busy, done}, 64'h0);
        check("start_abort_count", {48'h0, frame_count}, {48'h0, model_count});

        // Saturation: preload the counter near its limit
        do_start();
        force dut.frame_count_q = 16'hFFFD;
        @(negedge clk);
        release dut.frame_count_q;
        model_count = 16'hFFFD;
        for (int k = 0; k < 4; k++) rand_frame();
        send_frame(32'h0, 32'h0, -1, 0, 1'b0);

        // Asynchronous reset asserted off-edge during WRITE
        do_start();
        f = {32'hCAFE_F00D, 32'h0006_0123};
        for (int i = 0; i < 7; i++) send_byte(f[8*i +: 8], 0);
        byte_in    = f[63:56];
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("pre_reset_addr", {32'h0, config_addr}, {32'h0, f[31:0]});
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_addr", {32'h0, config_addr}, 64'h0);
        check("async_rst_data", {32'h0, config_data}, 64'h0);
        check("async_rst_flags", {61'h0, byte_ready, busy, done}, 64'h0);
        check("async_rst_count", {48'h0, frame_count}, 64'h0);
        model_bytes.delete();
        model_count = 16'h0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_start();
        rand_frame();
        send_frame(32'h0, 32'h0, -1, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
